// File: rtl/oc_word_seq_if.sv
// Request/result bundle between a requesting datapath (master) and the
// sequential ones-counter (slave).
interface oc_word_seq_if #(
    parameter int unsigned N = 16
);
    localparam int unsigned CW = $clog2(N + 1);

    logic          start;
    logic [N-1:0]  din;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;

    modport master (output start, din, input busy, done, count);
    modport slave  (input start, din, output busy, done, count);
endinterface

// File: rtl/oc_word_seq.sv
// Sequential ones-counter: walks an N-bit word three bits per clock through
// one shared 3-input ones-counter cell and accumulates the total.

module oc3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y1,
    output logic y0
);
    assign y1 = (a & b) | (a & c) | (b & c);
    assign y0 = a ^ b ^ c;
endmodule

module oc_word_seq #(
    parameter int unsigned N = 16
) (
    input  logic           clk,
    input  logic           rst,
    oc_word_seq_if.slave   bus
);
    localparam int unsigned K  = (N + 2) / 3;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned SW = 3 * K;
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sr_q, sr_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] idx_q, idx_d;

    logic          y1, y0;
    logic [CW-1:0] sum;

    oc3 u_oc3 (
        .a  (sr_q[0]),
        .b  (sr_q[1]),
        .c  (sr_q[2]),
        .y1 (y1),
        .y0 (y0)
    );

    assign sum = acc_q + CW'({y1, y0});

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        count_d = count_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Zero padding above bit N-1 keeps the last slice clean.
                    sr_d    = SW'(bus.din);
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                acc_d = sum;
                sr_d  = sr_q >> 3;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    count_d = sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.count = count_q;
endmodule
